// File: rtl/pipeline_regfile.sv
// pipeline_regfile
//   Register file for the 16-bit pipelined CPU with a per-register
//   pending-write scoreboard. Decode reads operands on NUM_READ combinational
//   ports and marks destinations busy at issue; writeback commits results and
//   retires the pending entry. rd_busy feeds the decode hazard/stall logic.
//
//   Optional feature macro: PIPELINE_REGFILE_ZERO_REG_EN
//     defined   -> register 0 is hardwired to zero, never busy, never counts
//     undefined -> register 0 is an ordinary register
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   rd_addr    in   NUM_READ packed read addresses (port i at [i*ADDR_W +: ADDR_W])
//   rd_data    out  NUM_READ packed read data, combinational
//   rd_busy    out  per-port flag: source register has an uncommitted write
//   wr_en      in   writeback commit strobe
//   wr_addr    in   writeback destination
//   wr_data    in   writeback value
//   issue_en   in   decode issued an instruction writing issue_addr
//   issue_addr in   destination of the issued instruction
//   flush      in   clears every pending counter
//   pend_ovf   out  sticky: an issue was dropped on a saturated counter
module pipeline_regfile #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_READ = 2,
  parameter int PEND_W   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         issue_en,
  input  logic [ADDR_W-1:0]            issue_addr,
  input  logic                         flush,
  output logic                         pend_ovf
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

`ifdef PIPELINE_REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [PEND_W-1:0] cnt_q  [NREGS];
  logic [PEND_W-1:0] cnt_d  [NREGS];
  logic              pend_ovf_q;
  logic              pend_ovf_d;

  logic wr_ok;
  logic iss_ok;
  logic same_addr;
  logic iss_sat;

  // Accesses to a hardwired zero register are dropped before they reach state.
  assign wr_ok  = wr_en    && !(ZERO_REG && (wr_addr    == '0));
  assign iss_ok = issue_en && !(ZERO_REG && (issue_addr == '0));

  // Issue and commit to one register in the same cycle cancel out, so that
  // case is neither an increment nor an overflow.
  assign same_addr = iss_ok && wr_en && (issue_addr == wr_addr);
  assign iss_sat   = iss_ok && !same_addr && (cnt_q[issue_addr] == PEND_MAX);

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      cnt_d[r]  = cnt_q[r];
      if (wr_ok && (wr_addr == ADDR_W'(r))) begin
        regs_d[r] = wr_data;
      end
      // Flush wins over counter updates, but not over the data commit above.
      if (flush) begin
        cnt_d[r] = '0;
      end else if (!same_addr) begin
        if (iss_ok && (issue_addr == ADDR_W'(r)) && (cnt_q[r] != PEND_MAX)) begin
          cnt_d[r] = cnt_q[r] + PEND_W'(1);
        end
        // An unscheduled commit (count 0) writes data but leaves the count at 0.
        if (wr_en && (wr_addr == ADDR_W'(r)) && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - PEND_W'(1);
        end
      end
    end
    pend_ovf_d = pend_ovf_q | (iss_sat && !flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      pend_ovf_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      pend_ovf_q <= pend_ovf_d;
    end
  end

  assign pend_ovf = pend_ovf_q;

  // Read ports: combinational lookup with optional write-first bypass.
  // Bypass is gated by rst_n so the ports show the zeroed file during reset.
  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic              zero;

    assign a    = rd_addr[g*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0) && rst_n && wr_en && (wr_addr == a);
    assign zero = ZERO_REG && (a == '0);

    assign rd_data[g*DATA_W +: DATA_W] = zero ? '0 : (hit ? wr_data : regs_q[a]);
    // The last outstanding write being committed right now is already
    // available through the bypass, so it no longer stalls decode.
    assign rd_busy[g] = !zero && (cnt_q[a] != '0) &&
                        !(hit && (cnt_q[a] == PEND_W'(1)));
  end

endmodule

// File: tb/tb_pipeline_regfile.sv
// tb_pipeline_regfile
//   Directed bench for pipeline_regfile at default parameters
//   (DATA_W=16, ADDR_W=3, NUM_READ=2, PEND_W=2, BYPASS=1).
//   Inputs change 1 time unit after a rising edge; outputs are sampled
//   2 time units after the rising edge.
module tb_pipeline_regfile;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_READ = 2;
  localparam int PEND_W   = 2;

  logic                       clk;
  logic                       rst_n;
  logic [NUM_READ*ADDR_W-1:0] rd_addr;
  logic [NUM_READ*DATA_W-1:0] rd_data;
  logic [NUM_READ-1:0]        rd_busy;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       issue_en;
  logic [ADDR_W-1:0]          issue_addr;
  logic                       flush;
  logic                       pend_ovf;

  int checks;
  int errors;

  pipeline_regfile #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_READ(NUM_READ),
    .PEND_W  (PEND_W),
    .BYPASS  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .flush     (flush),
    .pend_ovf  (pend_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit past the next rising edge, where inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    issue_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    rd_addr    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    issue_addr = '0;
    idle();

    // Power-on reset state
    #3;
    chk("por_rd0", 32'(rd_data[15:0]), 32'h0);
    chk("por_busy", 32'(rd_busy), 32'h0);
    chk("por_ovf", 32'(pend_ovf), 32'h0);
    #9 rst_n = 1'b1;

    // Write reg3, mark reg3 busy, then asynchronous reset mid-cycle
    tick();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h4444;
    tick();
    idle();
    issue_en = 1'b1; issue_addr = 3'd3;
    tick();
    idle();
    set_rd(3'd3, 3'd3);
    #1;
    chk("wr_reg3", 32'(rd_data[15:0]), 32'h4444);
    chk("busy_reg3", 32'(rd_busy), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd0", 32'(rd_data[15:0]), 32'h0);
    chk("rst_busy", 32'(rd_busy), 32'h0);
    chk("rst_ovf", 32'(pend_ovf), 32'h0);
    #2 rst_n = 1'b1;

    // Write-first bypass, both ports on the same address
    tick();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hFFFD;
    set_rd(3'd5, 3'd5);
    #1;
    chk("byp_rd0", 32'(rd_data[15:0]), 32'hFFFD);
    chk("byp_rd1", 32'(rd_data[31:16]), 32'hFFFD);
    tick();
    idle();
    #1;
    chk("wr5_stored", 32'(rd_data[15:0]), 32'hFFFD);

    // Scoreboard: two issues of reg2, then two commits
    set_rd(3'd2, 3'd5);
    issue_en = 1'b1; issue_addr = 3'd2;
    tick();
    tick();
    idle();
    #1;
    chk("sb_busy_2iss", 32'(rd_busy[0]), 32'h1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0022;
    #1;
    chk("sb_busy_commit1", 32'(rd_busy[0]), 32'h1);
    tick();
    idle();
    #1;
    chk("sb_busy_after1", 32'(rd_busy[0]), 32'h1);
    chk("sb_rd_after1", 32'(rd_data[15:0]), 32'h0022);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0023;
    #1;
    chk("sb_busy_commit2", 32'(rd_busy[0]), 32'h0);
    chk("sb_byp_commit2", 32'(rd_data[15:0]), 32'h0023);
    tick();
    idle();
    #1;
    chk("sb_busy_after2", 32'(rd_busy[0]), 32'h0);

    // Saturation: four issues of reg1, counter stops at 3
    set_rd(3'd1, 3'd2);
    issue_en = 1'b1; issue_addr = 3'd1;
    tick();
    tick();
    tick();
    #1;
    chk("sat_ovf_3iss", 32'(pend_ovf), 32'h0);
    tick();
    idle();
    #1;
    chk("sat_ovf_4iss", 32'(pend_ovf), 32'h1);
    chk("sat_busy", 32'(rd_busy[0]), 32'h1);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0101;
    tick();
    tick();
    idle();
    #1;
    chk("sat_busy_2com", 32'(rd_busy[0]), 32'h1);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0101;
    tick();
    idle();
    #1;
    chk("sat_busy_3com", 32'(rd_busy[0]), 32'h0);
    chk("sat_ovf_sticky", 32'(pend_ovf), 32'h1);

    // Simultaneous issue+commit on reg4, then flush with a write to reg6
    set_rd(3'd4, 3'd6);
    issue_en = 1'b1; issue_addr = 3'd4;
    tick();
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0044;
    tick();
    idle();
    #1;
    chk("simul_busy4", 32'(rd_busy[0]), 32'h1);
    chk("simul_rd4", 32'(rd_data[15:0]), 32'h0044);
    issue_en = 1'b1; issue_addr = 3'd6;
    flush = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0002;
    tick();
    idle();
    #1;
    chk("flush_busy", 32'(rd_busy), 32'h0);
    chk("flush_rd6", 32'(rd_data[31:16]), 32'h0002);

    // Register 0 behaviour, from a fresh reset so pend_ovf starts clear
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    set_rd(3'd4, 3'd0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1234;
    issue_en = 1'b1; issue_addr = 3'd0;
    tick();
    idle();
    issue_en = 1'b1; issue_addr = 3'd0;
    tick();
    idle();
    #1;
`ifdef PIPELINE_REGFILE_ZERO_REG_EN
    chk("zr_rd", 32'(rd_data[31:16]), 32'h0);
    chk("zr_busy", 32'(rd_busy[1]), 32'h0);
`else
    chk("r0_rd", 32'(rd_data[31:16]), 32'h1234);
    chk("r0_busy", 32'(rd_busy[1]), 32'h1);
`endif
    chk("r0_ovf", 32'(pend_ovf), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
